// File: rtl/stream_mux4_pkg.sv
// Shared definitions for the 4-channel stream merge path.
package stream_mux_pkg;

   localparam int unsigned N_CH  = 4;
   localparam int unsigned SEL_W = 2;

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

endpackage

// File: rtl/stream_mux4_if.sv
// Four valid/ready input channels plus one tagged output stream.
interface stream_mux4_if #(
   parameter int unsigned DATA_W = 8
);
   import stream_mux_pkg::*;

   logic [N_CH-1:0]        in_valid;
   logic [N_CH-1:0]        in_last;
   logic [N_CH*DATA_W-1:0] in_data;
   logic [N_CH-1:0]        in_ready;
   logic                   out_valid;
   logic                   out_last;
   logic [DATA_W-1:0]      out_data;
   logic [SEL_W-1:0]       out_sel;
   logic                   out_ready;

   modport master (
      output in_valid, in_last, in_data, out_ready,
      input  in_ready, out_valid, out_last, out_data, out_sel
   );

   modport slave (
      input  in_valid, in_last, in_data, out_ready,
      output in_ready, out_valid, out_last, out_data, out_sel
   );

endinterface

// File: rtl/stream_mux4_arb.sv
// Combinational rotating-priority arbiter: search starts just after last_ptr.
module rr_arbiter4
   import stream_mux_pkg::*;
(
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] last_ptr,
   output logic [N_CH-1:0]  grant,
   output logic [SEL_W-1:0] grant_idx
);

   logic [SEL_W-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      idx       = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         idx = last_ptr + SEL_W'(i + 1);
         if (req[idx] && (grant == '0)) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/stream_mux4.sv
// 4-to-1 packet-aware round-robin stream merge with a registered output stage.
module stream_mux4
   import stream_mux_pkg::*;
#(
   parameter int unsigned DATA_W = 8
)
(
   input  logic         clk,
   input  logic         rst,
   stream_mux4_if.slave bus
);

   state_t            state, state_n;
   logic [SEL_W-1:0]  lock_ch, lock_ch_n;
   logic [SEL_W-1:0]  last_ptr, last_ptr_n;
   logic [N_CH-1:0]   req, grant;
   logic [SEL_W-1:0]  grant_idx;
   logic              load_en, xfer;
   logic              beat_last;
   logic [DATA_W-1:0] beat_data;

   logic              out_valid_q, out_last_q;
   logic [DATA_W-1:0] out_data_q;
   logic [SEL_W-1:0]  out_sel_q;

   // While locked only the packet owner may request, so the arbiter grants it alone.
   always_comb begin
      load_en = !out_valid_q || bus.out_ready;
      req     = (state == ST_LOCK) ? (bus.in_valid & (N_CH'(1) << lock_ch)) : bus.in_valid;
   end

   rr_arbiter4 u_arb (
      .req       (req),
      .last_ptr  (last_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign bus.in_ready = (load_en && !rst) ? grant : '0;
   assign xfer         = |bus.in_ready;
   assign beat_data    = bus.in_data[grant_idx*DATA_W +: DATA_W];
   assign beat_last    = bus.in_last[grant_idx];

   always_comb begin
      state_n    = state;
      lock_ch_n  = lock_ch;
      last_ptr_n = last_ptr;
      if (xfer) begin
         unique case (state)
            ST_ARB: begin
               if (beat_last) begin
                  last_ptr_n = grant_idx;
               end else begin
                  state_n   = ST_LOCK;
                  lock_ch_n = grant_idx;
               end
            end
            ST_LOCK: begin
               if (beat_last) begin
                  state_n    = ST_ARB;
                  last_ptr_n = lock_ch;
               end
            end
            default: state_n = ST_ARB;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_ARB;
         lock_ch  <= '0;
         last_ptr <= '1;
      end else begin
         state    <= state_n;
         lock_ch  <= lock_ch_n;
         last_ptr <= last_ptr_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else if (load_en) begin
         if (xfer) begin
            out_valid_q <= 1'b1;
            out_last_q  <= beat_last;
            out_data_q  <= beat_data;
            out_sel_q   <= grant_idx;
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux4.sv
// Randomized scoreboard bench for stream_mux4 with a packet-level reference model.
module tb_stream_mux4;
   import stream_mux_pkg::*;

   localparam int unsigned DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   stream_mux4_if #(.DATA_W(DW)) bus ();

   stream_mux4 #(.DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [8:0]  pq [4][$];   // per-source pending beats {last, data}
   logic [10:0] sb [$];      // expected output beats {sel, last, data}
   logic [3:0]  acc = '0;
   bit          rst_cmd = 1'b1;
   bit          flush_pending = 1'b0;
   int          idle_pct = 0;
   int          ready_pct = 100;
   int          mptr = 3;
   int          mlock = -1;
   bit          mvalid = 1'b0;
   int unsigned tag = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endfunction

   function automatic void add_pkt(int ch, int nbeats);
      for (int b = 0; b < nbeats; b++) begin
         pq[ch].push_back({(b == nbeats - 1), 8'(tag)});
         tag++;
      end
   endfunction

   // One cycle: drive at negedge, then predict this cycle's handshake from the packet rules.
   task automatic step();
      logic [3:0] erdy;
      int         g;
      bit         load;
      @(negedge clk);
      if (flush_pending) begin
         sb.delete();
         flush_pending = 1'b0;
      end
      rst = rst_cmd;
      for (int k = 0; k < 4; k++) begin
         if (acc[k] && pq[k].size() > 0) void'(pq[k].pop_front());
         if (!(bus.in_valid[k] && !acc[k] && pq[k].size() > 0))
            bus.in_valid[k] = (pq[k].size() > 0) && ($urandom_range(99) >= idle_pct);
         if (pq[k].size() > 0) begin
            bus.in_last[k]            = pq[k][0][8];
            bus.in_data[k*DW +: DW]   = pq[k][0][7:0];
         end
      end
      bus.out_ready = ($urandom_range(99) < ready_pct);
      #2;
      g    = -1;
      load = !mvalid || bus.out_ready;
      if (mlock >= 0) begin
         if (bus.in_valid[mlock]) g = mlock;
      end else begin
         for (int i = 1; i <= 4; i++) begin
            int c;
            c = (mptr + i) % 4;
            if (g < 0 && bus.in_valid[c]) g = c;
         end
      end
      erdy = (rst || !load || g < 0) ? 4'b0 : 4'(1 << g);
      check("in_ready", 32'(bus.in_ready), 32'(erdy));
      acc = bus.in_valid & bus.in_ready;
      if (rst) begin
         mvalid = 1'b0;
         mlock  = -1;
         mptr   = 3;
         for (int k = 0; k < 4; k++) pq[k].delete();
         flush_pending = 1'b1;
      end else if (erdy != 4'b0) begin
         sb.push_back({2'(g), pq[g][0]});
         if (pq[g][0][8]) begin
            mlock = -1;
            mptr  = g;
         end else begin
            mlock = g;
         end
         mvalid = 1'b1;
      end else if (load) begin
         mvalid = 1'b0;
      end
   endtask

   task automatic drain();
      bit done;
      done      = 1'b0;
      ready_pct = 100;
      idle_pct  = 0;
      for (int n = 0; n < 200 && !done; n++) begin
         step();
         done = (sb.size() == 0) && (pq[0].size() == 0) && (pq[1].size() == 0) &&
                (pq[2].size() == 0) && (pq[3].size() == 0);
      end
      if (!done) check("drain_timeout", 32'd1, 32'd0);
   endtask

   // Output monitor: pops the scoreboard on every output handshake.
   initial begin
      logic [11:0] prev;
      logic [10:0] e;
      bit          hold;
      prev = '0;
      hold = 1'b0;
      forever begin
         @(negedge clk);
         #3;
         if (hold)
            check("stall_stable", 32'({bus.out_valid, bus.out_sel, bus.out_last, bus.out_data}), 32'(prev));
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_beat", 32'({bus.out_sel, bus.out_last, bus.out_data}), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check("out_beat", 32'({bus.out_sel, bus.out_last, bus.out_data}), 32'(e));
            end
         end
         hold = bus.out_valid && !bus.out_ready && !rst;
         prev = {bus.out_valid, bus.out_sel, bus.out_last, bus.out_data};
      end
   end

   initial begin
      bit got;
      bus.in_valid  = '0;
      bus.in_last   = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      // Reset with every source requesting
      for (int k = 0; k < 4; k++) add_pkt(k, 1);
      rst_cmd = 1'b1;
      repeat (2) step();
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_sel",   32'(bus.out_sel),   32'd0);
      check("rst_out_data",  32'(bus.out_data),  32'd0);
      check("rst_out_last",  32'(bus.out_last),  32'd0);
      rst_cmd = 1'b0;

      // Single beat on channel 2
      pq[2].push_back({1'b1, 8'hA5});
      drain();

      // Back-to-back single beats on all channels
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < 4; k++) add_pkt(k, 1);
      drain();

      // Multi-beat packet on ch1 competing with ch0/ch3
      pq[1].push_back({1'b0, 8'h11});
      pq[1].push_back({1'b0, 8'h12});
      pq[1].push_back({1'b1, 8'h13});
      add_pkt(0, 1);
      add_pkt(3, 1);
      drain();

      // Output backpressure while sources wait
      for (int k = 0; k < 4; k++) add_pkt(k, 2);
      ready_pct = 100;
      step();
      step();
      ready_pct = 0;
      repeat (5) step();
      drain();

      // Reset after the first beat of a 4-beat ch0 packet
      add_pkt(0, 4);
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         step();
         got = acc[0];
      end
      if (!got) check("midpkt_timeout", 32'd1, 32'd0);
      rst_cmd = 1'b1;
      step();
      rst_cmd = 1'b0;
      add_pkt(3, 1);
      drain();

      // Random traffic
      idle_pct  = 25;
      ready_pct = 70;
      for (int n = 0; n < 3000; n++) begin
         for (int k = 0; k < 4; k++)
            if (pq[k].size() == 0 && $urandom_range(99) < 30)
               add_pkt(k, int'($urandom_range(1, 4)));
         rst_cmd = ($urandom_range(499) == 0);
         step();
         idle_pct  = 25;
         ready_pct = 70;
      end
      rst_cmd = 1'b0;
      drain();
      step();
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
